// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide execution unit.
//
// Takes rs1/rs2 values and the M-extension funct3, computes over several cycles and
// returns a one-cycle registered write-back pulse (result/rd_out/we_out) that feeds the
// register-file write port. The core stalls while busy is high.
//
// Ports:
//   clk     in   clock, all state updates on the rising edge
//   rst_n   in   synchronous active-low reset
//   start   in   request, sampled only while idle
//   funct3  in   000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
//                100 DIV, 101 DIVU, 110 REM, 111 REMU
//   op_a    in   rs1 value
//   op_b    in   rs2 value
//   rd_in   in   destination register index
//   kill    in   pipeline flush, aborts the in-flight op
//   busy    out  op in flight
//   done    out  one-cycle completion pulse
//   result  out  result, zero unless done
//   rd_out  out  latched rd_in, zero unless done
//   we_out  out  done && rd_out != 0
//
// Build option: define MULDIV_FAST_MUL_EN to replace the 1 bit/cycle shift-add
// multiplier by a single registered 33x33 signed multiply (MUL state lasts one cycle).
// Divide behaviour is the same in both builds.

module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            we_out
);

  localparam int unsigned CntW = $clog2(XLEN) + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(XLEN - 1);
  localparam logic [XLEN-1:0] MinInt  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] AllOnes = '1;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StFinish} state_e;

  state_e            state_q, state_d;
  logic [2:0]        f3_q, f3_d;
  logic [4:0]        rd_q, rd_d;
  // Multiplicand / divisor (fast build: raw op_a)
  logic [XLEN-1:0]   opnd_q, opnd_d;
  // Mul: {product hi, multiplier/product lo}. Div: {remainder, dividend/quotient}.
  // Special cases park the final result in the low half.
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic              neg_q, neg_d;       // negate product / quotient
  logic              rneg_q, rneg_d;     // negate remainder
  logic              special_q, special_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              done_q, done_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [4:0]        rd_out_q, rd_out_d;
  logic              we_q, we_d;

  // Decode of the incoming request
  logic            in_div, in_rem, in_a_signed, in_b_signed, a_neg, b_neg;
  logic [XLEN-1:0] mag_a, mag_b;

  always_comb begin
    in_div      = funct3[2];
    in_rem      = funct3[1];
    in_a_signed = in_div ? ~funct3[0] : (funct3[1:0] != 2'b11);
    in_b_signed = in_div ? ~funct3[0] : ~funct3[1];
    a_neg       = in_a_signed & op_a[XLEN-1];
    b_neg       = in_b_signed & op_b[XLEN-1];
    mag_a       = a_neg ? -op_a : op_a;
    mag_b       = b_neg ? -op_b : op_b;
  end

  // Restoring divide step on {remainder, dividend}
  logic [XLEN:0]   div_shift;
  logic            div_ge;
  logic [XLEN-1:0] div_diff, div_rem;

  always_comb begin
    div_shift = acc_q[2*XLEN-1:XLEN-1];
    div_ge    = div_shift >= {1'b0, opnd_q};
    // When div_ge holds the difference is below the divisor, so XLEN bits suffice.
    div_diff  = div_shift[XLEN-1:0] - opnd_q;
    div_rem   = div_ge ? div_diff : div_shift[XLEN-1:0];
  end

`ifdef MULDIV_FAST_MUL_EN
  // 33-bit signed operands, sign-extended to the product width; the bits above
  // 2*XLEN of the 33x33 product are never needed.
  logic              fa_signed, fb_signed;
  logic [XLEN:0]     fa, fb;
  logic [2*XLEN-1:0] fast_prod;

  always_comb begin
    fa_signed = (f3_q[1:0] != 2'b11);
    fb_signed = ~f3_q[1];
    fa        = {fa_signed & opnd_q[XLEN-1], opnd_q};
    fb        = {fb_signed & acc_q[XLEN-1], acc_q[XLEN-1:0]};
    fast_prod = $signed({{(XLEN-1){fa[XLEN]}}, fa}) * $signed({{(XLEN-1){fb[XLEN]}}, fb});
  end
`else
  // Shift-add step: conditionally add multiplicand into the high half
  logic [XLEN:0] mul_sum;

  always_comb begin
    mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  end
`endif

  // Sign correction and result select
  logic [2*XLEN-1:0] prod_c;
  logic [XLEN-1:0]   quo_c, rem_c, fin_res;

  always_comb begin
    prod_c = neg_q ? -acc_q : acc_q;
    quo_c  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_c  = rneg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    if (special_q) begin
      fin_res = acc_q[XLEN-1:0];
    end else if (f3_q[2]) begin
      fin_res = f3_q[1] ? rem_c : quo_c;
    end else if (f3_q[1:0] == 2'b00) begin
      fin_res = prod_c[XLEN-1:0];
    end else begin
      fin_res = prod_c[2*XLEN-1:XLEN];
    end
  end

  always_comb begin
    state_d   = state_q;
    f3_d      = f3_q;
    rd_d      = rd_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    neg_d     = neg_q;
    rneg_d    = rneg_q;
    special_d = special_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    result_d  = '0;
    rd_out_d  = '0;
    we_d      = 1'b0;

    case (state_q)
      StIdle: begin
        if (start && !kill) begin
          f3_d      = funct3;
          rd_d      = rd_in;
          cnt_d     = '0;
          special_d = 1'b0;
          neg_d     = a_neg ^ b_neg;
          rneg_d    = a_neg;
          if (in_div) begin
            if (op_b == '0) begin
              special_d = 1'b1;
              acc_d     = {{XLEN{1'b0}}, (in_rem ? op_a : AllOnes)};
              state_d   = StFinish;
            end else if (in_a_signed && op_a == MinInt && op_b == AllOnes) begin
              special_d = 1'b1;
              acc_d     = {{XLEN{1'b0}}, (in_rem ? {XLEN{1'b0}} : MinInt)};
              state_d   = StFinish;
            end else begin
              opnd_d  = mag_b;
              acc_d   = {{XLEN{1'b0}}, mag_a};
              state_d = StDiv;
            end
          end else begin
`ifdef MULDIV_FAST_MUL_EN
            opnd_d = op_a;
            acc_d  = {{XLEN{1'b0}}, op_b};
            neg_d  = 1'b0;
`else
            opnd_d = mag_a;
            acc_d  = {{XLEN{1'b0}}, mag_b};
`endif
            state_d = StMul;
          end
        end
      end

      StMul: begin
        if (kill) begin
          state_d = StIdle;
        end else begin
`ifdef MULDIV_FAST_MUL_EN
          acc_d   = fast_prod;
          state_d = StFinish;
`else
          acc_d = {mul_sum, acc_q[XLEN-1:1]};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            state_d = StFinish;
          end
`endif
        end
      end

      StDiv: begin
        if (kill) begin
          state_d = StIdle;
        end else begin
          acc_d = {div_rem, acc_q[XLEN-2:0], div_ge};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            state_d = StFinish;
          end
        end
      end

      StFinish: begin
        state_d = StIdle;
        if (!kill) begin
          done_d   = 1'b1;
          result_d = fin_res;
          rd_out_d = rd_q;
          we_d     = (rd_q != 5'd0);
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      f3_q      <= '0;
      rd_q      <= '0;
      opnd_q    <= '0;
      acc_q     <= '0;
      neg_q     <= 1'b0;
      rneg_q    <= 1'b0;
      special_q <= 1'b0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      result_q  <= '0;
      rd_out_q  <= '0;
      we_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      f3_q      <= f3_d;
      rd_q      <= rd_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      neg_q     <= neg_d;
      rneg_q    <= rneg_d;
      special_q <= special_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      result_q  <= result_d;
      rd_out_q  <= rd_out_d;
      we_q      <= we_d;
    end
  end

  assign busy   = (state_q != StIdle);
  assign done   = done_q;
  assign result = result_q;
  assign rd_out = rd_out_q;
  assign we_out = we_q;

endmodule
